// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues instruction memory reads at PC, fills the IF/ID latch,
// parks a hit in a hold buffer while decode stalls, and drains reads orphaned by a flush.
module fetch_stage #(
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [WORD_W-1:0] PC,
  input  logic [WORD_W-1:0] npc,
  output logic              pc_en,
  output logic              iREN,
  output logic [WORD_W-1:0] iaddr,
  input  logic              ihit,
  input  logic [WORD_W-1:0] iload,
  input  logic              stall,
  input  logic              flush,
  output logic [WORD_W-1:0] ifid_instr,
  output logic [WORD_W-1:0] ifid_pc,
  output logic [WORD_W-1:0] ifid_npc,
  output logic              ifid_valid,
  output logic [1:0]        dbg_state
);

  // FETCH: request at PC. HOLD: hit parked in buffer, no request.
  // DRAIN: finish a request flushed before its hit, data is dropped.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [WORD_W-1:0] drain_addr, drain_addr_n;
  logic [WORD_W-1:0] hold_instr, hold_instr_n;
  logic [WORD_W-1:0] hold_pc, hold_pc_n;
  logic [WORD_W-1:0] hold_npc, hold_npc_n;
  logic [WORD_W-1:0] ifid_instr_n, ifid_pc_n, ifid_npc_n;
  logic              ifid_valid_n;

  assign dbg_state = state;

  always_comb begin
    state_n      = state;
    drain_addr_n = drain_addr;
    hold_instr_n = hold_instr;
    hold_pc_n    = hold_pc;
    hold_npc_n   = hold_npc;
    ifid_instr_n = ifid_instr;
    ifid_pc_n    = ifid_pc;
    ifid_npc_n   = ifid_npc;
    ifid_valid_n = ifid_valid;
    pc_en        = 1'b0;
    iREN         = 1'b0;
    iaddr        = PC;

    case (state)
      FETCH: begin
        iREN  = 1'b1;
        iaddr = PC;
        pc_en = flush | ihit;
        if (flush) begin
          ifid_valid_n = 1'b0;
          if (!ihit) begin
            drain_addr_n = PC;
            state_n      = DRAIN;
          end
        end else if (ihit) begin
          if (stall) begin
            hold_instr_n = iload;
            hold_pc_n    = PC;
            hold_npc_n   = npc;
            state_n      = HOLD;
          end else begin
            ifid_instr_n = iload;
            ifid_pc_n    = PC;
            ifid_npc_n   = npc;
            ifid_valid_n = 1'b1;
          end
        end else if (!stall) begin
          ifid_valid_n = 1'b0;
        end
      end

      HOLD: begin
        pc_en = flush;
        if (flush) begin
          ifid_valid_n = 1'b0;
          state_n      = FETCH;
        end else if (!stall) begin
          ifid_instr_n = hold_instr;
          ifid_pc_n    = hold_pc;
          ifid_npc_n   = hold_npc;
          ifid_valid_n = 1'b1;
          state_n      = FETCH;
        end
      end

      DRAIN: begin
        // The memory still owes a hit for drain_addr; keep asking until it arrives.
        iREN  = 1'b1;
        iaddr = drain_addr;
        pc_en = flush;
        if (flush) ifid_valid_n = 1'b0;
        if (ihit)  state_n = FETCH;
      end

      default: state_n = FETCH;
    endcase

    if (RST) begin
      pc_en = 1'b0;
      iREN  = 1'b0;
      iaddr = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= FETCH;
      drain_addr <= '0;
      hold_instr <= '0;
      hold_pc    <= '0;
      hold_npc   <= '0;
      ifid_instr <= '0;
      ifid_pc    <= '0;
      ifid_npc   <= '0;
      ifid_valid <= 1'b0;
    end else begin
      state      <= state_n;
      drain_addr <= drain_addr_n;
      hold_instr <= hold_instr_n;
      hold_pc    <= hold_pc_n;
      hold_npc   <= hold_npc_n;
      ifid_instr <= ifid_instr_n;
      ifid_pc    <= ifid_pc_n;
      ifid_npc   <= ifid_npc_n;
      ifid_valid <= ifid_valid_n;
    end
  end

endmodule
